// File: rtl/iserdes_bitslip_calib.sv
// Word-alignment controller for the 1:8 DDR ISERDES read lanes.
// It resets the ISERDES bank and then trains one lane at a time. On each lane it
// issues BITSLIP pulses until the deserialized word matches PATTERN for
// MATCH_COUNT consecutive cycles.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for i_start after reset
// ISRST  | one setup cycle, then ISERDES RST held high for RST_CYCLES
// SETTLE | waiting for the lane word to stabilise; i_data is ignored
// CHECK  | comparing the current lane word with PATTERN, counting the run
// SLIP   | single-cycle BITSLIP on the current lane
// NEXT   | lane finished (locked or failed); advance or finish
// DONE   | calibration complete; results held until the next i_start
module iserdes_bitslip_calib #(
  parameter int          LANES         = 8,
  parameter logic [7:0]  PATTERN       = 8'h3C,
  parameter int          RST_CYCLES    = 4,
  parameter int          SETTLE_CYCLES = 3,
  parameter int          MATCH_COUNT   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [LANES*8-1:0]   i_data,
  output logic                 o_iserdes_rst,
  output logic [LANES-1:0]     o_bitslip,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [LANES-1:0]     o_fail,
  output logic [LANES*3-1:0]   o_slip_count
);

  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int MW   = $clog2(MATCH_COUNT + 1);

  typedef enum logic [2:0] {
    IDLE, ISRST, SETTLE, CHECK, SLIP, NEXT, DONE
  } state_t;

  state_t          state;
  logic [LW-1:0]   lane;
  logic [CW-1:0]   cnt;
  logic [MW-1:0]   match_cnt;
  logic [2:0]      slip_q [LANES];
  logic [7:0]      word;
  logic [2:0]      slip_cur;

  assign word     = i_data[int'(lane)*8 +: 8];
  assign slip_cur = slip_q[lane];

  // Expose the per-lane slip registers as the packed count bus.
  for (genvar k = 0; k < LANES; k++) begin : g_cnt
    assign o_slip_count[3*k +: 3] = slip_q[k];
  end

  // Calibration sequencer: state, timers and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      lane          <= '0;
      cnt           <= '0;
      match_cnt     <= '0;
      o_iserdes_rst <= 1'b0;
      o_bitslip     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_fail        <= '0;
      for (int k = 0; k < LANES; k++) slip_q[k] <= 3'd0;
    end else begin
      o_bitslip <= '0;
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state  <= ISRST;
            lane   <= '0;
            cnt    <= CW'(RST_CYCLES);
            o_busy <= 1'b1;
            o_done <= 1'b0;
            o_fail <= '0;
            for (int k = 0; k < LANES; k++) slip_q[k] <= 3'd0;
          end
        end
        ISRST: begin
          if (cnt != '0) begin
            o_iserdes_rst <= 1'b1;
            cnt           <= cnt - 1'b1;
          end else begin
            o_iserdes_rst <= 1'b0;
            cnt           <= CW'(SETTLE_CYCLES - 1);
            state         <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            match_cnt <= '0;
            state     <= CHECK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CHECK: begin
          if (word == PATTERN) begin
            if (match_cnt == MW'(MATCH_COUNT - 1)) state <= NEXT;
            else match_cnt <= match_cnt + 1'b1;
          end else if (slip_cur != 3'd7) begin
            // The slip is counted on the same edge that raises the pulse.
            o_bitslip[lane] <= 1'b1;
            slip_q[lane]    <= slip_cur + 3'd1;
            state           <= SLIP;
          end else begin
            // All eight rotations have been tried; the lane stays at seven slips.
            o_fail[lane] <= 1'b1;
            state        <= NEXT;
          end
        end
        SLIP: begin
          cnt   <= CW'(SETTLE_CYCLES - 1);
          state <= SETTLE;
        end
        NEXT: begin
          if (lane == LW'(LANES - 1)) begin
            state  <= DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else begin
            lane  <= lane + 1'b1;
            cnt   <= CW'(SETTLE_CYCLES - 1);
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iserdes_bitslip_calib.sv
// Self-checking bench for iserdes_bitslip_calib.
// A behavioural ISERDES per lane tracks the applied bitslips. The expected slips,
// fail flags and completion time are derived from the lane behaviour.
module tb_iserdes_bitslip_calib;
  localparam int         LANES = 8;
  localparam int         R     = 4;
  localparam int         S     = 3;
  localparam int         M     = 4;
  localparam logic [7:0] PAT   = 8'h3C;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic                 i_start = 1'b0;
  logic [LANES*8-1:0]   i_data;
  logic                 o_iserdes_rst;
  logic [LANES-1:0]     o_bitslip;
  logic                 o_busy;
  logic                 o_done;
  logic [LANES-1:0]     o_fail;
  logic [LANES*3-1:0]   o_slip_count;

  iserdes_bitslip_calib dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_data(i_data),
    .o_iserdes_rst(o_iserdes_rst), .o_bitslip(o_bitslip), .o_busy(o_busy),
    .o_done(o_done), .o_fail(o_fail), .o_slip_count(o_slip_count)
  );

  always #5 i_clk = ~i_clk;

  // Lane behaviour: 0 = rotated by off, 1 = stuck value, 2 = partial match then one slip
  int         mode  [LANES];
  int         off   [LANES];
  logic [7:0] stuck [LANES];
  int         slips [LANES];
  int         cyc_since_rst;

  int pulses [LANES];
  int rst_hi, viol_onehot, viol_gap, viol_rst, cyc;
  int last_pulse = -100;
  int n_tests = 0, n_fail = 0;

  function automatic logic [7:0] rotl(input logic [7:0] v, input int r);
    logic [15:0] d;
    d = {v, v} << r;
    return d[15:8];
  endfunction

  always_comb begin
    i_data = '0;
    for (int k = 0; k < LANES; k++) begin
      case (mode[k])
        1:       i_data[k*8 +: 8] = stuck[k];
        2:       i_data[k*8 +: 8] = (slips[k] > 0 || cyc_since_rst <= 6) ? PAT : 8'h00;
        default: i_data[k*8 +: 8] = rotl(PAT, (off[k] - slips[k]) & 7);
      endcase
    end
  end

  // Behavioural ISERDES plus the bitslip/reset protocol monitor.
  always @(negedge i_clk) begin
    cyc++;
    if (o_iserdes_rst) begin
      rst_hi++;
      cyc_since_rst = 0;
      for (int k = 0; k < LANES; k++) slips[k] = 0;
    end else begin
      cyc_since_rst++;
    end
    if (o_bitslip != '0) begin
      if ($countones(o_bitslip) != 1) viol_onehot++;
      if (o_iserdes_rst) viol_rst++;
      if (cyc - last_pulse < S + 1) viol_gap++;
      last_pulse = cyc;
      for (int k = 0; k < LANES; k++)
        if (o_bitslip[k]) begin
          pulses[k]++;
          slips[k]++;
        end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_aligned();
    for (int k = 0; k < LANES; k++) begin
      mode[k] = 0; off[k] = 0; stuck[k] = 8'h00;
    end
  endtask

  // One calibration run; expected results come from the lane behaviour table.
  task automatic run_cal(input string name, input int restart_at);
    int n, es, exp_edges;
    int p0 [LANES];
    int r0;
    logic [LANES-1:0]   exp_fail;
    logic [LANES*3-1:0] exp_sc;
    r0 = rst_hi;
    for (int k = 0; k < LANES; k++) p0[k] = pulses[k];
    exp_edges = R + 1;
    exp_fail  = '0;
    exp_sc    = '0;
    for (int k = 0; k < LANES; k++) begin
      case (mode[k])
        1: begin es = 7; exp_fail[k] = 1'b1; exp_edges += S + 7*(S+2) + 2; end
        2: begin es = 1; exp_edges += 2*S + M + 6; end
        default: begin es = off[k]; exp_edges += S + M + 1 + off[k]*(S+2); end
      endcase
      exp_sc[3*k +: 3] = 3'(es);
    end
    @(negedge i_clk) i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    chk({name, ":busy_after_start"}, o_busy, 1);
    n = 0;
    while (!o_done && n < 3000) begin
      @(posedge i_clk);
      #1 n++;
      i_start = (n == restart_at);
    end
    i_start = 1'b0;
    chk({name, ":done_latency"}, n, exp_edges);
    chk({name, ":busy_end"}, o_busy, 0);
    chk({name, ":fail"}, o_fail, exp_fail);
    chk({name, ":slip_count"}, o_slip_count, exp_sc);
    chk({name, ":rst_cycles"}, rst_hi - r0, R);
    for (int k = 0; k < LANES; k++)
      chk($sformatf("%s:pulses%0d", name, k), pulses[k] - p0[k], exp_sc[3*k +: 3]);
    chk({name, ":onehot"}, viol_onehot, 0);
    chk({name, ":gap"}, viol_gap, 0);
    chk({name, ":slip_in_rst"}, viol_rst, 0);
    repeat (3) @(posedge i_clk);
    #1 chk({name, ":done_held"}, o_done, 1);
  endtask

  initial begin
    int n;
    set_aligned();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset:rst", o_iserdes_rst, 0);
    chk("reset:bitslip", o_bitslip, 0);
    chk("reset:busy", o_busy, 0);
    chk("reset:done", o_done, 0);
    chk("reset:fail", o_fail, 0);
    chk("reset:slip_count", o_slip_count, 0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    run_cal("aligned", -1);

    set_aligned(); off[2] = 3;
    run_cal("rotated", -1);

    set_aligned(); mode[5] = 1; stuck[5] = 8'h00;
    run_cal("dead", -1);

    set_aligned(); mode[0] = 2;
    run_cal("intermittent", -1);

    set_aligned(); off[5] = 3;
    run_cal("start_busy", 32);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < LANES; k++) begin
        int r;
        r = $urandom_range(0, 9);
        mode[k] = 0; off[k] = 0; stuck[k] = 8'h00;
        if (r < 6) off[k] = $urandom_range(0, 7);
        else if (r < 8) begin mode[k] = 1; stuck[k] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00; end
      end
      run_cal($sformatf("random%0d", t), -1);
    end

    set_aligned(); off[4] = 2;
    @(negedge i_clk) i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    n = 0;
    while (!o_bitslip[4] && n < 2000) begin
      @(posedge i_clk);
      #1 n++;
    end
    chk("midrst:bitslip4_seen", o_bitslip[4], 1);
    i_rst_n = 1'b0;
    #1;
    chk("midrst:bitslip", o_bitslip, 0);
    chk("midrst:busy", o_busy, 0);
    chk("midrst:rst", o_iserdes_rst, 0);
    chk("midrst:done", o_done, 0);
    chk("midrst:fail", o_fail, 0);
    chk("midrst:slip_count", o_slip_count, 0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    set_aligned();
    run_cal("after_rst", -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
